// File: rtl/bus_arbiter_target.sv
// bus_arbiter_target
//   Single responder on the client rq/ack bus. Picks one requesting client
//   round-robin, latches its address/data/direction, performs the access on
//   an internal register-file memory after MEM_LATENCY cycles and returns a
//   one-cycle ack (plus read data for reads).
//
// Ports
//   clk_i     bus clock, rising edge
//   rst_ni    asynchronous active-low reset
//   rq_i      per-client request, held until ack
//   wr_ni_i   per-client direction (0 = write, 1 = read)
//   addr_i    packed client addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_i   packed client write data, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack_o     one-hot completion pulse to the served client
//   gnt_o     one-hot grant, high from GRANT through ACK
//   rdata_o   read data, valid while ack_o is high for a read
//   busy_o    high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for an unmasked request
// GRANT  | winner granted, its address/data/direction latched
// ACCESS | memory access in progress for MEM_LATENCY cycles
// ACK    | one-cycle ack to the winner
module bus_arbiter_target #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_CLIENTS-1:0]           rq_i,
  input  logic [NUM_CLIENTS-1:0]           wr_ni_i,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_CLIENTS-1:0]           ack_o,
  output logic [NUM_CLIENTS-1:0]           gnt_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             busy_o
);

  localparam int PW    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCESS, S_ACK} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           win_q, win_d;
  logic [NUM_CLIENTS-1:0]  mask_q, mask_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wr_n_q, wr_n_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]  eligible;
  logic [NUM_CLIENTS-1:0]  win_oh;
  logic [PW-1:0]           pick, cand;
  logic                    found;
  logic                    access_done;
  logic                    mem_we;

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The client acked last cycle is hidden for one IDLE cycle so a requester
  // whose rq falls a cycle late is not served twice.
  assign eligible    = rq_i & ~mask_q;
  assign win_oh      = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << win_q;
  assign access_done = (state_q == S_ACCESS) && (cnt_q == CW'(MEM_LATENCY - 1));
  assign mem_we      = access_done && !wr_n_q;

  // Round-robin search upward from the pointer, wrapping modulo NUM_CLIENTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_CLIENTS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_n_q  <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_n_q  <= wr_n_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; the write strobe is gated by the FSM state, so an
  // asynchronous reset during ACCESS drops the pending write.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[addr_q] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    mask_d  = '0;
    cnt_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_n_d  = wr_n_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        addr_d  = addr_arr[win_q];
        wdata_d = wdata_arr[win_q];
        wr_n_d  = wr_ni_i[win_q];
        ptr_d   = PW'((int'(win_q) + 1) % NUM_CLIENTS);
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (access_done) begin
          if (wr_n_q) rdata_d = mem_q[addr_q];
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        mask_d  = win_oh;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = '0;
    ack_o  = '0;
    busy_o = (state_q != S_IDLE);
    if (state_q != S_IDLE) gnt_o = win_oh;
    if (state_q == S_ACK)  ack_o = win_oh;
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_bus_arbiter_target.sv
// tb_bus_arbiter_target
//   Directed and randomized checks of bus_arbiter_target. A transaction-level
//   model (round-robin pick, memory array, expected cycle counts) predicts
//   every grant, ack, read value and latency. Three instances cover
//   MEM_LATENCY = 2 (main), 1 and 5.
module tb_bus_arbiter_target;
  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0]    rq_m = '0, rq_1 = '0, rq_5 = '0;
  logic [N-1:0]    wr_n = '1;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack_m, gnt_m, ack_1, gnt_1, ack_5, gnt_5;
  logic [DW-1:0]   rdata_m, rdata_1, rdata_5;
  logic            busy_m, busy_1, busy_5;

  always #5 clk = ~clk;

  bus_arbiter_target #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .rq_i(rq_m), .wr_ni_i(wr_n), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_m), .gnt_o(gnt_m), .rdata_o(rdata_m), .busy_o(busy_m));
  bus_arbiter_target #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .rq_i(rq_1), .wr_ni_i(wr_n), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_1), .gnt_o(gnt_1), .rdata_o(rdata_1), .busy_o(busy_1));
  bus_arbiter_target #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(5)) u_lat5 (
    .clk_i(clk), .rst_ni(rst_n), .rq_i(rq_5), .wr_ni_i(wr_n), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_5), .gnt_o(gnt_5), .rdata_o(rdata_5), .busy_o(busy_5));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [DW-1:0] ref_mem   [256];
  bit            ref_known [256];
  int            ref_ptr = 0;
  logic          op_wr_n [N];
  logic [AW-1:0] op_a    [N];
  logic [DW-1:0] op_d    [N];
  int            served[$];
  int            last_ack_cyc = 0;
  logic [DW-1:0] last_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_n[c]          = wr;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
    op_wr_n[c] = wr;
    op_a[c]    = a;
    op_d[c]    = d;
  endtask

  function automatic int model_pick(input logic [N-1:0] pend);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (ref_ptr + i) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    check("rst_ack",   32'(ack_m),   32'd0);
    check("rst_gnt",   32'(gnt_m),   32'd0);
    check("rst_rdata", 32'(rdata_m), 32'd0);
    check("rst_busy",  32'(busy_m),  32'd0);
    tick;
    tick;
    rst_n   = 1'b1;
    ref_ptr = 0;
    tick;
  endtask

  // Raise now_set at once (late_set two cycles later), hold each rq until one
  // cycle after its ack, and check every grant/ack against the model.
  task automatic round(input logic [N-1:0] now_set, input logic [N-1:0] late_set, input bit perturb);
    logic [N-1:0] pend, d1, d2;
    int cyc, gcyc, w, exp_g;
    bit in_txn;
    pend = now_set; d1 = '0; d2 = '0;
    cyc = 0; gcyc = 0; w = 0; exp_g = 1; in_txn = 1'b0;
    served.delete();
    rq_m = now_set;
    while ((pend != '0 || in_txn) && cyc < 300) begin
      tick;
      cyc++;
      rq_m &= ~d2;
      d2 = d1;
      d1 = '0;
      check("gnt_onehot0",     32'($onehot0(gnt_m)), 32'd1);
      check("ack_implies_gnt", 32'(ack_m & ~gnt_m),  32'd0);
      if (in_txn) begin
        check("gnt_hold", 32'(gnt_m),  32'(1) << w);
        check("busy_txn", 32'(busy_m), 32'd1);
        if (ack_m != '0) begin
          check("ack_who",  32'(ack_m),  32'(1) << w);
          check("ack_time", 32'(cyc - gcyc), 32'(1 + LAT));
          if (op_wr_n[w]) begin
            check("rdata", 32'(rdata_m), 32'(ref_mem[op_a[w]]));
            last_rdata = rdata_m;
          end else begin
            ref_mem[op_a[w]]   = op_d[w];
            ref_known[op_a[w]] = 1'b1;
          end
          ref_ptr = (w + 1) % N;
          pend[w] = 1'b0;
          d1[w]   = 1'b1;
          served.push_back(w);
          last_ack_cyc = cyc;
          exp_g  = cyc + 2;
          in_txn = 1'b0;
        end else if (perturb && cyc == gcyc + 1) begin
          wr_n[w]           = ~op_wr_n[w];
          addr[w*AW +: AW]  = op_a[w] + 8'd1;
          wdata[w*DW +: DW] = ~op_d[w];
        end
      end else if (gnt_m != '0) begin
        w = model_pick(pend);
        check("grant_who",  32'(gnt_m), 32'(1) << w);
        check("grant_time", 32'(cyc),   32'(exp_g));
        in_txn = 1'b1;
        gcyc   = cyc;
      end
      if (cyc == 2 && late_set != '0) begin
        rq_m |= late_set;
        pend |= late_set;
      end
    end
    check("round_timeout", 32'(cyc >= 300), 32'd0);
    tick;
    rq_m &= ~d2;
    tick;
    // the last-served client is still requesting here, but must not be regranted
    check("mask_no_regrant", 32'(busy_m), 32'd0);
    rq_m = '0;
    tick;
  endtask

  task automatic lat_txn(input int sel, input int c, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    int cyc, lat;
    logic [N-1:0] ack, gnt;
    logic [DW-1:0] rd;
    logic busy;
    set_client(c, wr, a, d);
    lat = (sel == 1) ? 1 : 5;
    if (sel == 1) rq_1[c] = 1'b1;
    else          rq_5[c] = 1'b1;
    cyc = 0; ack = '0; gnt = '0; rd = '0;
    while (ack == '0 && cyc < 50) begin
      tick;
      cyc++;
      ack = (sel == 1) ? ack_1 : ack_5;
      gnt = (sel == 1) ? gnt_1 : gnt_5;
      rd  = (sel == 1) ? rdata_1 : rdata_5;
    end
    check("lat_cycle",   32'(cyc), 32'(2 + lat));
    check("lat_ack_who", 32'(ack), 32'(1) << c);
    check("lat_gnt_ack", 32'(gnt), 32'(1) << c);
    if (wr) check("lat_rdata", 32'(rd), 32'(exp_rd));
    rq_1 = '0;
    rq_5 = '0;
    tick;
    tick;
    busy = (sel == 1) ? busy_1 : busy_5;
    check("lat_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, prev;
    logic [N-1:0] now_set, late_set;
    logic [AW-1:0] a, a1, a5;
    logic [DW-1:0] d1v, d5v;
    logic wr;

    #2;
    do_reset;

    // single write then read by client 0
    set_client(0, 1'b0, 8'h10, 8'hA5);
    round(4'b0001, 4'b0000, 1'b0);
    check("wr_ack_cycle", 32'(last_ack_cyc), 32'd4);
    set_client(0, 1'b1, 8'h10, 8'h00);
    round(4'b0001, 4'b0000, 1'b0);
    check("rd_ack_cycle", 32'(last_ack_cyc), 32'd4);
    check("rd_a5",        32'(last_rdata),   32'hA5);

    // granted client's inputs changing during ACCESS have no effect
    set_client(2, 1'b0, 8'h45, 8'h11);
    round(4'b0100, 4'b0000, 1'b0);
    set_client(2, 1'b0, 8'h44, 8'h5A);
    round(4'b0100, 4'b0000, 1'b1);
    set_client(1, 1'b1, 8'h44, 8'h00);
    round(4'b0010, 4'b0000, 1'b0);
    check("perturb_addr", 32'(last_rdata), 32'h5A);
    set_client(1, 1'b1, 8'h45, 8'h00);
    round(4'b0010, 4'b0000, 1'b0);
    check("perturb_next", 32'(last_rdata), 32'h11);

    // round-robin with all requests held continuously
    do_reset;
    for (int c = 0; c < N; c++) set_client(c, 1'b1, 8'h10, 8'h00);
    rq_m = '1;
    cyc = 0; n = 0; prev = 0;
    while (n < 5 && cyc < 100) begin
      tick;
      cyc++;
      check("rr_gnt_onehot", 32'($onehot0(gnt_m)), 32'd1);
      if (ack_m != '0) begin
        check("rr_order", 32'(ack_m),   32'(1) << (n % N));
        check("rr_rdata", 32'(rdata_m), 32'hA5);
        if (n == 0) check("rr_first",   32'(cyc),        32'(2 + LAT));
        else        check("rr_spacing", 32'(cyc - prev), 32'(3 + LAT));
        prev = cyc;
        n++;
        if (n == 5) rq_m = '0;
      end
    end
    check("rr_count", 32'(n), 32'd5);
    tick;
    tick;
    check("rr_idle", 32'(busy_m), 32'd0);
    ref_ptr = 1;

    // pointer wrap: after client 3, clients 1 and 3 -> 1 first
    set_client(3, 1'b1, 8'h10, 8'h00);
    round(4'b1000, 4'b0000, 1'b0);
    set_client(1, 1'b1, 8'h10, 8'h00);
    set_client(3, 1'b1, 8'h10, 8'h00);
    round(4'b1010, 4'b0000, 1'b0);
    check("wrap_count",  32'(served.size()), 32'd2);
    check("wrap_first",  32'(served[0]),     32'd1);
    check("wrap_second", 32'(served[1]),     32'd3);

    // last-served mask
    set_client(2, 1'b0, 8'h30, 8'($urandom_range(0, 255)));
    round(4'b0100, 4'b0000, 1'b0);
    set_client(2, 1'b1, 8'h30, 8'h00);
    set_client(1, 1'b1, 8'h10, 8'h00);
    round(4'b0100, 4'b0010, 1'b0);
    check("mask_count",  32'(served.size()), 32'd2);
    check("mask_first",  32'(served[0]),     32'd2);
    check("mask_second", 32'(served[1]),     32'd1);

    // reset during ACCESS abandons the write
    set_client(1, 1'b0, 8'h20, 8'h00);
    round(4'b0010, 4'b0000, 1'b0);
    set_client(1, 1'b0, 8'h20, 8'h3C);
    rq_m[1] = 1'b1;
    tick;
    tick;
    tick;
    check("midrst_busy_before", 32'(busy_m), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ack",   32'(ack_m),   32'd0);
    check("midrst_gnt",   32'(gnt_m),   32'd0);
    check("midrst_busy",  32'(busy_m),  32'd0);
    check("midrst_rdata", 32'(rdata_m), 32'd0);
    tick;
    tick;
    check("midrst_no_ack", 32'(ack_m), 32'd0);
    rq_m  = '0;
    rst_n = 1'b1;
    ref_ptr = 0;
    tick;
    set_client(1, 1'b1, 8'h20, 8'h00);
    round(4'b0010, 4'b0000, 1'b0);
    check("midrst_readback", 32'(last_rdata), 32'h00);

    // randomized rounds against the model
    for (int r = 0; r < 25; r++) begin
      now_set  = 4'($urandom_range(1, 15));
      late_set = ($urandom_range(0, 2) == 0) ? (4'($urandom_range(0, 15)) & ~now_set) : 4'b0000;
      for (int c = 0; c < N; c++) begin
        a  = 8'h80 + 8'($urandom_range(0, 15));
        wr = ref_known[a] ? 1'($urandom_range(0, 1)) : 1'b0;
        set_client(c, wr, a, 8'($urandom_range(0, 255)));
      end
      round(now_set, late_set, 1'($urandom_range(0, 1)));
    end

    // latency sweep
    a1  = 8'($urandom_range(0, 255));
    d1v = 8'($urandom_range(0, 255));
    lat_txn(1, 0, 1'b0, a1, d1v, 8'h00);
    lat_txn(1, 2, 1'b1, a1, 8'h00, d1v);
    a5  = 8'($urandom_range(0, 255));
    d5v = 8'($urandom_range(0, 255));
    lat_txn(5, 3, 1'b0, a5, d5v, 8'h00);
    lat_txn(5, 1, 1'b1, a5, 8'h00, d5v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_target.md
Name: bus_arbiter_target

Overview:
Responder end of the client rq/ack bus. Arbitrates round-robin among NUM_CLIENTS bus clients, latches the winning client's address, data and wr_ni, and performs the access on an internal register-file memory after MEM_LATENCY cycles. Returns a one-cycle ack to that client and, for reads, the read data. Sits between the client_control_logic instances and shared storage; it is the single target on the bus.

Parameters:
NUM_CLIENTS, 4, number of requesting clients (2..8)
ADDR_WIDTH, 8, client address width; memory depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, data word width
MEM_LATENCY, 2, cycles spent in ACCESS state (>=1)

Ports:
clk  input  1  bus clock, rising edge
rst  input  1  asynchronous, active-low reset
rq  input  NUM_CLIENTS  per-client request, held high until ack
wr_ni  input  NUM_CLIENTS  per-client direction: 0 = write, 1 = read
addr  input  NUM_CLIENTS*ADDR_WIDTH  packed client addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  input  NUM_CLIENTS*DATA_WIDTH  packed client write data, client i at [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  NUM_CLIENTS  one-hot, one-cycle completion pulse to the served client
gnt  output  NUM_CLIENTS  one-hot grant, high from GRANT through ACK
rdata  output  DATA_WIDTH  read data, valid while ack is high for a read
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ack=0, gnt=0, rdata=0, busy=0, rr pointer=0, last-served mask cleared. Memory contents are not reset.
- Reset asserted mid-transaction: the transaction is abandoned. No ack is issued and a pending write is not performed.
- FSM states: IDLE, GRANT, ACCESS, ACK.
- IDLE: if any unmasked rq is high, select a winner and go to GRANT. Otherwise stay in IDLE.
- Winner selection: the first requesting client found searching upward from the rr pointer, wrapping modulo NUM_CLIENTS.
- GRANT (1 cycle): gnt[winner]=1. Latch addr, wdata and wr_ni of the winner. Rr pointer <= (winner+1) mod NUM_CLIENTS. Go to ACCESS.
- ACCESS: lasts exactly MEM_LATENCY cycles, using an internal counter cleared on entry.
  - Write: memory[latched addr] <= latched wdata on the clock edge that leaves ACCESS.
  - Read: rdata <= memory[latched addr] on the same edge.
- ACK (1 cycle): ack[winner]=1, gnt held. Next state is IDLE.
- rdata is held until the next read completes. It is not cleared for writes.
- Latency: rq sampled high on edge 0 -> GRANT in cycle 1 -> ACCESS in cycles 2..1+MEM_LATENCY -> ack in cycle 2+MEM_LATENCY.
  - With MEM_LATENCY=2, ack is high in cycle 4.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Last-served mask: during the single IDLE cycle after ACK, the client just acked is ignored. This covers a client whose rq falls one cycle after ack. The mask clears after that cycle.
- rq dropped before ack: the transaction completes normally and the ack is still pulsed (defined behaviour for a protocol violation).
- Inputs of non-granted clients are ignored. Changes to the granted client's addr, wdata or wr_ni after GRANT have no effect.
- Simultaneous requests: exactly one grant. Others wait, and no request is lost.
- Address wrap: addresses are used modulo 2**ADDR_WIDTH, with no out-of-range case.
- Invariants: ack and gnt are always zero or one-hot. ack implies gnt on the same bit.

Test Plan:
- Reset then single write, then read: client 0 writes wr_ni=0, addr=0x10, wdata=0xA5 -> ack[0] in cycle 4 after rq sampled. Then client 0 reads addr=0x10 -> ack[0] with rdata=0xA5.
- Round-robin fairness: all four rq held high continuously -> ack order 0,1,2,3,0, one transaction every 5 cycles (MEM_LATENCY=2), gnt always one-hot.
- Pointer wrap: after client 3 is served, clients 1 and 3 request -> client 1 granted first, then client 3.
- Last-served mask: client 2 keeps rq high one cycle after its ack while client 1 also requests -> client 1 granted next, no duplicate service of client 2.
- Reset mid-ACCESS: client 1 writes 0x3C to addr 0x20 and rst is pulled low in ACCESS -> outputs go to zero immediately and no ack is issued. A subsequent read of 0x20 does not return 0x3C (pre-written 0x00 returns 0x00).
- Latency sweep: MEM_LATENCY=1 and MEM_LATENCY=5 -> ack appears exactly 2+MEM_LATENCY cycles after rq sampled, and read data is correct.
